// File: rtl/hifp_avm_pkg.sv
// Shared definitions for the HIFP local-memory Avalon-MM responder:
// default bus geometry, burstcount width and the responder state encoding.
package hifp_avm_pkg;

  localparam int DATA_W     = 512;
  localparam int ADDR_W     = 32;
  localparam int DEPTH_LOG2 = 8;
  localparam int BURST_W    = 5;
  localparam int MAX_BURST  = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2
  } state_e;

endpackage

// File: rtl/hifp_byteen_ram.sv
// Simple dual-port word RAM: one byte-enabled write port and one read port
// whose output is registered (data appears the cycle after the address).
// Contents are never reset.
module hifp_byteen_ram #(
  parameter int DATA_W     = 512,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  import hifp_avm_pkg::*;

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Byte-granular write; bytes with a clear enable keep their old contents.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wbe[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read, issued every cycle; the responder tracks which are real.
  always_ff @(posedge clock) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hifp_local_mem_responder.sv
// Avalon-MM burst responder in front of a local byte-enabled RAM.
// Reads: beat 0 is looked up in the accept cycle, the rest one per cycle in
// RD_BURST; data returns through the RAM register plus one output register,
// so a read accepted at T yields readdatavalid at T+2 .. T+1+N.
// Writes: each accepted beat commits directly and is acknowledged next cycle.
module hifp_local_mem_responder #(
  parameter int DATA_W     = hifp_avm_pkg::DATA_W,
  parameter int ADDR_W     = hifp_avm_pkg::ADDR_W,
  parameter int DEPTH_LOG2 = hifp_avm_pkg::DEPTH_LOG2,
  parameter int MAX_BURST  = hifp_avm_pkg::MAX_BURST
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [ADDR_W-1:0]                 avs_address,
  input  logic                              avs_read,
  input  logic                              avs_write,
  input  logic [DATA_W-1:0]                 avs_writedata,
  input  logic [DATA_W/8-1:0]               avs_byteenable,
  input  logic [hifp_avm_pkg::BURST_W-1:0]  avs_burstcount,
  output logic                              avs_waitrequest,
  output logic [DATA_W-1:0]                 avs_readdata,
  output logic                              avs_readdatavalid,
  output logic                              avs_writeack,
  output logic                              busy,
  output logic                              protocol_error
);

  import hifp_avm_pkg::*;

  localparam int WORD_LSB = 6;
  localparam int CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [DEPTH_LOG2-1:0] WORD_ONE = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  // Burstcount 0 counts as a single beat; anything above MAX_BURST saturates.
  function automatic logic [CNT_W-1:0] sat_burst(input logic [BURST_W-1:0] bc);
    if (bc == '0) return CNT_ONE;
    if (int'(bc) > MAX_BURST) return CNT_W'(MAX_BURST);
    return CNT_W'(bc);
  endfunction

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      left_q, left_d;
  logic                  err_q;

  logic [DEPTH_LOG2-1:0] cmd_word;
  logic [CNT_W-1:0]      cmd_len;
  logic                  bc_over;
  logic                  acc_wr;
  logic                  acc_rd;
  logic                  err_set;

  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  rd_issue;

  logic                  vld_p0;
  logic                  vld_p1;
  logic                  wack_p0;
  logic [DATA_W-1:0]     readdata_p1;

  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{avs_address[ADDR_W-1:WORD_LSB+DEPTH_LOG2],
                              avs_address[WORD_LSB-1:0]};

  assign cmd_word = avs_address[WORD_LSB +: DEPTH_LOG2];
  assign cmd_len  = sat_burst(avs_burstcount);
  assign bc_over  = int'(avs_burstcount) > MAX_BURST;

  // Waitrequest is only raised while reads are being issued, and in reset.
  assign avs_waitrequest = reset | (state_q == ST_RD_BURST);

  // A write wins over a simultaneous read; reads start bursts only from IDLE.
  assign acc_wr = avs_write & ~avs_waitrequest;
  assign acc_rd = avs_read & ~avs_write & ~avs_waitrequest & (state_q == ST_IDLE);

  // Next-state, burst address/count and RAM port control.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    ram_we    = 1'b0;
    ram_waddr = cmd_word;
    ram_raddr = cmd_word;
    rd_issue  = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_wr) begin
          ram_we  = 1'b1;
          err_set = avs_read | bc_over;
          if (cmd_len != CNT_ONE) begin
            state_d = ST_WR_BURST;
            addr_d  = cmd_word + WORD_ONE;
            left_d  = cmd_len - CNT_ONE;
          end
        end else if (acc_rd) begin
          rd_issue = 1'b1;
          err_set  = bc_over;
          state_d  = ST_RD_BURST;
          addr_d   = cmd_word + WORD_ONE;
          left_d   = cmd_len - CNT_ONE;
        end
      end
      ST_RD_BURST: begin
        ram_raddr = addr_q;
        if (left_q != '0) begin
          rd_issue = 1'b1;
          addr_d   = addr_q + WORD_ONE;
          left_d   = left_q - CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        ram_waddr = addr_q;
        err_set   = avs_read;
        if (acc_wr) begin
          ram_we = 1'b1;
          addr_d = addr_q + WORD_ONE;
          left_d = left_q - CNT_ONE;
          if (left_q == CNT_ONE) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state: FSM, burst counter, valid/ack pipeline and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      wack_p0 <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      vld_p0  <= rd_issue;
      vld_p1  <= vld_p0;
      wack_p0 <= ram_we;
      err_q   <= err_q | err_set;
    end
  end

  // Burst word address; only meaningful while a burst is active.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
  end

  hifp_byteen_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (avs_writedata),
    .wbe   (avs_byteenable),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // p0 -> p1: output register stage for read data.
  always_ff @(posedge clock) begin
    if (vld_p0) begin
      readdata_p1 <= ram_rdata;
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign avs_readdata      = reset ? '0 : readdata_p1;
  assign avs_readdatavalid = vld_p1 & ~reset;
  assign avs_writeack      = wack_p0 & ~reset;
  assign protocol_error    = err_q & ~reset;
  assign busy              = ~reset & ((state_q != ST_IDLE) | vld_p0 | vld_p1);

endmodule

// File: tb/tb_hifp_local_mem_responder.sv
// Directed bench for hifp_local_mem_responder: reset behaviour, single and
// burst write/read timing, byte enables, address wrap, error cases and
// reset in the middle of a read burst.
module tb_hifp_local_mem_responder;

  logic         clock;
  logic         reset;
  logic [31:0]  avs_address;
  logic         avs_read;
  logic         avs_write;
  logic [511:0] avs_writedata;
  logic [63:0]  avs_byteenable;
  logic [4:0]   avs_burstcount;
  logic         avs_waitrequest;
  logic [511:0] avs_readdata;
  logic         avs_readdatavalid;
  logic         avs_writeack;
  logic         busy;
  logic         protocol_error;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  int beat_cnt;

  hifp_local_mem_responder dut (
    .clock             (clock),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_writeack      (avs_writeack),
    .busy              (busy),
    .protocol_error    (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Labelled word value used to identify which RAM word a beat came from.
  function automatic logic [511:0] pat(input int k);
    logic [511:0] v;
    v = '0;
    v[511:496] = 16'hBEEF;
    v[31:0] = k;
    return v;
  endfunction

  initial begin
    reset          = 1'b1;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_address    = '0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    avs_burstcount = 5'd1;

    // Reset state
    next_cycle();
    mid();
    chk("rst_waitrequest", avs_waitrequest, 1);
    chk("rst_readdatavalid", avs_readdatavalid, 0);
    chk("rst_writeack", avs_writeack, 0);
    chk("rst_readdata", avs_readdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_protocol_error", protocol_error, 0);
    next_cycle();
    reset = 1'b0;
    mid();
    chk("rst_release_waitrequest", avs_waitrequest, 0);

    // Single write of 0xA5 pattern to 0x40, then single read back
    next_cycle();
    avs_write = 1'b1; avs_address = 32'h40; avs_writedata = {64{8'hA5}};
    avs_byteenable = '1; avs_burstcount = 5'd1;
    mid();
    chk("wr1_waitrequest", avs_waitrequest, 0);
    next_cycle();
    avs_write = 1'b0;
    mid();
    chk("wr1_writeack", avs_writeack, 1);
    next_cycle();
    mid();
    chk("wr1_writeack_once", avs_writeack, 0);
    next_cycle();
    avs_read = 1'b1; avs_address = 32'h40;
    mid();
    chk("rd1_accept", avs_waitrequest, 0);
    next_cycle();
    avs_read = 1'b0;
    mid();
    chk("rd1_valid_t1", avs_readdatavalid, 0);
    chk("rd1_wait_t1", avs_waitrequest, 1);
    next_cycle();
    mid();
    chk("rd1_valid_t2", avs_readdatavalid, 1);
    chk("rd1_data", avs_readdata, {64{8'hA5}});
    next_cycle();
    mid();
    chk("rd1_valid_t3", avs_readdatavalid, 0);
    chk("rd1_wait_t3", avs_waitrequest, 0);

    // Write burst of 4 words (1..4) at 0x0, address ignored after beat 0
    next_cycle();
    avs_write = 1'b1; avs_address = 32'h0; avs_burstcount = 5'd4; avs_writedata = 512'd1;
    mid();
    for (int k = 2; k <= 4; k++) begin
      next_cycle();
      avs_address = 32'h1234_5FC0;
      avs_writedata = 512'(k);
      mid();
      chk("wrb_writeack", avs_writeack, 1);
      chk("wrb_waitrequest", avs_waitrequest, 0);
    end
    next_cycle();
    avs_write = 1'b0; avs_read = 1'b1; avs_address = 32'h0; avs_burstcount = 5'd4;
    mid();
    chk("wrb_last_writeack", avs_writeack, 1);
    chk("rdb_accept", avs_waitrequest, 0);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      avs_read = 1'b0;
      mid();
      chk("rdb_waitrequest", avs_waitrequest, (i <= 4));
      chk("rdb_valid", avs_readdatavalid, (i >= 2));
      if (i >= 2) chk("rdb_data", avs_readdata, 512'(i - 1));
    end
    next_cycle();
    mid();
    chk("rdb_valid_end", avs_readdatavalid, 0);

    // Byte-enable: only byte 0 of a zeroed word is written
    next_cycle();
    avs_write = 1'b1; avs_address = 32'h80; avs_writedata = '0;
    avs_byteenable = '1; avs_burstcount = 5'd1;
    mid();
    next_cycle();
    avs_writedata = '1; avs_byteenable = 64'h1;
    mid();
    next_cycle();
    avs_write = 1'b0; avs_read = 1'b1; avs_address = 32'h80;
    mid();
    next_cycle();
    avs_read = 1'b0;
    mid();
    next_cycle();
    mid();
    chk("be_valid", avs_readdatavalid, 1);
    chk("be_data", avs_readdata, 512'hFF);

    // Write then read a 16-beat burst starting at word 250 (wraps past 255)
    next_cycle();
    avs_write = 1'b1; avs_address = 32'hABCD_3E80; avs_burstcount = 5'd16;
    avs_byteenable = '1; avs_writedata = pat(250);
    mid();
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      avs_writedata = pat((250 + k) % 256);
      mid();
    end
    next_cycle();
    avs_write = 1'b0; avs_read = 1'b1; avs_address = 32'hABCD_3E80; avs_burstcount = 5'd16;
    mid();
    for (int i = 1; i <= 18; i++) begin
      next_cycle();
      avs_read = 1'b0;
      mid();
      chk("wrap_valid", avs_readdatavalid, (i >= 2 && i <= 17));
      if (i >= 2 && i <= 17) chk("wrap_data", avs_readdata, pat((248 + i) % 256));
    end
    chk("wrap_no_error", protocol_error, 0);

    // Read and write together: write only, error flag set and sticky
    next_cycle();
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 32'h1C0;
    avs_writedata = {64{8'h5A}}; avs_byteenable = '1; avs_burstcount = 5'd1;
    mid();
    chk("rw_accept", avs_waitrequest, 0);
    next_cycle();
    avs_read = 1'b0; avs_write = 1'b0;
    mid();
    chk("rw_writeack", avs_writeack, 1);
    chk("rw_protocol_error", protocol_error, 1);
    chk("rw_no_valid_a", avs_readdatavalid, 0);
    next_cycle();
    mid();
    chk("rw_no_valid_b", avs_readdatavalid, 0);
    chk("rw_no_rd_burst", avs_waitrequest, 0);

    // Burstcount 0 read acts as a single beat
    next_cycle();
    avs_read = 1'b1; avs_address = 32'h1C0; avs_burstcount = 5'd0;
    mid();
    next_cycle();
    avs_read = 1'b0;
    mid();
    chk("bc0_wait", avs_waitrequest, 1);
    next_cycle();
    mid();
    chk("bc0_valid", avs_readdatavalid, 1);
    chk("bc0_data", avs_readdata, {64{8'h5A}});
    chk("bc0_wait_done", avs_waitrequest, 0);
    next_cycle();
    mid();
    chk("bc0_valid_end", avs_readdatavalid, 0);
    chk("rw_error_sticky", protocol_error, 1);

    // Oversized burstcount saturates at 16 beats
    next_cycle();
    avs_read = 1'b1; avs_address = 32'h0; avs_burstcount = 5'd31;
    mid();
    next_cycle();
    avs_read = 1'b0;
    beat_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      mid();
      if (avs_readdatavalid) beat_cnt++;
      next_cycle();
    end
    chk("clamp_beats", beat_cnt, 16);

    // Reset during the third beat of an 8-beat read
    avs_read = 1'b1; avs_address = 32'h0; avs_burstcount = 5'd8;
    mid();
    next_cycle();
    avs_read = 1'b0;
    mid();
    next_cycle();
    mid();
    chk("rst8_beat1_data", avs_readdata, pat(0));
    next_cycle();
    mid();
    chk("rst8_beat2_data", avs_readdata, pat(1));
    next_cycle();
    reset = 1'b1;
    mid();
    chk("rst8_valid_in_reset", avs_readdatavalid, 0);
    chk("rst8_wait_in_reset", avs_waitrequest, 1);
    chk("rst8_busy_in_reset", busy, 0);
    chk("rst8_data_in_reset", avs_readdata, 0);
    chk("rst8_error_in_reset", protocol_error, 0);
    next_cycle();
    reset = 1'b0;
    mid();
    chk("rst8_wait_after", avs_waitrequest, 0);
    chk("rst8_valid_after", avs_readdatavalid, 0);
    chk("rst8_error_cleared", protocol_error, 0);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      mid();
      chk("rst8_no_valid", avs_readdatavalid, 0);
      chk("rst8_not_busy", busy, 0);
    end

    // Read raised during a write burst is ignored but flagged
    next_cycle();
    avs_write = 1'b1; avs_address = 32'h500; avs_burstcount = 5'd2;
    avs_byteenable = '1; avs_writedata = pat(77);
    mid();
    next_cycle();
    avs_read = 1'b1; avs_writedata = pat(78);
    mid();
    chk("wrrd_waitrequest", avs_waitrequest, 0);
    next_cycle();
    avs_read = 1'b0; avs_write = 1'b0;
    mid();
    chk("wrrd_writeack", avs_writeack, 1);
    chk("wrrd_protocol_error", protocol_error, 1);
    chk("wrrd_no_valid_a", avs_readdatavalid, 0);
    next_cycle();
    avs_read = 1'b1; avs_address = 32'h500; avs_burstcount = 5'd2;
    mid();
    chk("wrrd_no_valid_b", avs_readdatavalid, 0);
    next_cycle();
    avs_read = 1'b0;
    mid();
    next_cycle();
    mid();
    chk("wrrd_beat0_valid", avs_readdatavalid, 1);
    chk("wrrd_beat0_data", avs_readdata, pat(77));
    next_cycle();
    mid();
    chk("wrrd_beat1_valid", avs_readdatavalid, 1);
    chk("wrrd_beat1_data", avs_readdata, pat(78));
    next_cycle();
    mid();
    chk("wrrd_end_valid", avs_readdatavalid, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
